// File: rtl/regfile_pkg.sv
// Shared sizing for the register-file write-back path: index/data widths,
// register count and the default number of write-back producers.
package regfile_pkg;

  localparam int REG_W           = 5;
  localparam int DATA_W          = 32;
  localparam int NUM_REGS        = 32;
  localparam int NUM_REQ_DEFAULT = 3;

  // Width of an index into a vector of n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request after the last winner,
// wrapping modulo N. The last pointer advances only on a completed transfer.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = regfile_pkg::idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          update,
  input  logic [IW-1:0] grant_idx,
  output logic [N-1:0]  grant
);

  logic [IW-1:0] last;
  logic [IW-1:0] idx;
  logic          found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(N - 1);
    end else if (update) begin
      last <= grant_idx;
    end
  end

  // Scan last+1 .. last+N so the previous winner is considered last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file: round-robin selection among
// producers, one registered write stage, and a pending-destination scoreboard.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = regfile_pkg::NUM_REQ_DEFAULT,
  parameter int REG_W   = regfile_pkg::REG_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*REG_W-1:0]  req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_stall,
  input  logic                      issue_valid,
  input  logic [REG_W-1:0]          issue_reg,
  output logic                      issue_ready,
  input  logic [REG_W-1:0]          query_reg_a,
  input  logic [REG_W-1:0]          query_reg_b,
  output logic                      pending_a,
  output logic                      pending_b,
  output logic                      write_register_d,
  output logic [REG_W-1:0]          register_d,
  output logic [DATA_W-1:0]         data_register_d_in
);

  import regfile_pkg::*;

  localparam int IW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]  arb_req;
  logic [IW-1:0]       grant_idx;
  logic                xfer;
  logic [NUM_REGS-1:0] pending;

  // Stall masks the request vector so no grant can be produced.
  assign arb_req = req_valid & {NUM_REQ{~wb_stall}};

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (reset),
    .req       (arb_req),
    .update    (xfer),
    .grant_idx (grant_idx),
    .grant     (req_ready)
  );

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) grant_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_register_d   <= 1'b0;
      register_d         <= '0;
      data_register_d_in <= '0;
    end else begin
      write_register_d <= xfer;
      if (xfer) begin
        register_d         <= req_reg[grant_idx*REG_W +: REG_W];
        data_register_d_in <= req_data[grant_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign issue_ready = ~pending[issue_reg];
  assign pending_a   = pending[query_reg_a];
  assign pending_b   = pending[query_reg_b];

  // Clear before set: a same-index collision cannot occur since issue is
  // refused while the index is pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      if (write_register_d) pending[register_d] <= 1'b0;
      if (issue_valid && issue_ready) pending[issue_reg] <= 1'b1;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between NUM_REQ write-back producers (ALU, load unit, multi-cycle unit).
- Arbitration is round-robin with a valid/ready handshake, followed by one registered output stage that drives the register file write port directly.
- Holds a 32-entry pending scoreboard: a destination is marked on issue and cleared on its write-back, and two read-port queries report hazards to the decode stage.
- Sits between the execute units and the register file.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8).
- REG_W, 5, register index width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  NUM_REQ  per-requester write-back request.
- req_reg  input  NUM_REQ*REG_W  destination index; requester i uses slice [i*REG_W +: REG_W].
- req_data  input  NUM_REQ*DATA_W  write data; requester i uses slice [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  grant, one-hot or zero.
- wb_stall  input  1  suppresses new grants.
- issue_valid  input  1  decode issues an instruction with destination issue_reg.
- issue_reg  input  REG_W  destination index to mark pending.
- issue_ready  output  1  issue accepted this cycle.
- query_reg_a  input  REG_W  source A index.
- query_reg_b  input  REG_W  source B index.
- pending_a  output  1  source A has an outstanding write.
- pending_b  output  1  source B has an outstanding write.
- write_register_d  output  1  register file write enable.
- register_d  output  REG_W  register file write index.
- data_register_d_in  output  DATA_W  register file write data.

Behaviour:
- Reset (reset==0, asynchronous):
  - write_register_d=0, register_d=0, data_register_d_in=0.
  - All pending bits=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
- Arbitration (combinational):
  - When wb_stall=0, the first i with req_valid[i]=1 is granted, scanning from last+1 upward with wrap modulo NUM_REQ.
  - req_ready[i]=1 for that i only.
  - When wb_stall=1 or no request is valid, req_ready is all zeros.
  - req_ready never depends on req_data or req_reg.
- Handshake:
  - A transfer occurs at a rising edge where req_valid[i] & req_ready[i].
  - On a transfer, last<=i. Otherwise last holds.
  - A requester holds valid, reg and data stable until it is granted. Dropping valid before grant is allowed; nothing is written.
- Output stage, 1-cycle latency:
  - A transfer at edge T gives write_register_d=1 with register_d/data_register_d_in equal to the granted slices during cycle T..T+1. The register file samples this at edge T+1.
  - With no transfer, write_register_d<=0; register_d and data hold their previous values.
  - Back-to-back transfers give a write every cycle. Throughput is 1 write/cycle.
- Scoreboard:
  - issue_ready = ~pending[issue_reg].
  - On issue_valid & issue_ready: pending[issue_reg]<=1.
  - While write_register_d=1 at an edge: pending[register_d]<=0.
  - Same index set and cleared at the same edge cannot occur, because issue_ready is low while the index is pending.
  - Different indices set and cleared at the same edge are both applied.
- Queries:
  - pending_a = pending[query_reg_a] and pending_b = pending[query_reg_b]. Both are combinational from state.
  - No forwarding: a register is reported pending through the cycle its write is presented on the port. It reads clear from the cycle after.
- Write-back without prior issue: the write still happens. The clear of an unset bit is harmless.
- Index 0 is an ordinary register; no special case.
- Reset mid-operation:
  - The output-stage write is dropped and all pending bits are cleared.
  - Requesters re-present after reset deasserts.
- wb_stall rising while the output stage is full: the in-flight write still completes next edge. No new grants are made.

Decomposition:
- Shared package regfile_pkg: REG_W, DATA_W, NUM_REGS=32, NUM_REQ default.
- Sub-module rr_arbiter (parameter N): req vector, update strobe and granted index in; one-hot grant out; owns the last pointer.
- The scoreboard and output stage stay in the top module.

Test Plan:
1. Reset release, no requests -> all outputs 0, req_ready=000, pending_a=pending_b=0.
2. req0 alone (reg 5, data 0xDEADBEEF) at cycle 1 -> req_ready=001 in cycle 1; cycle 2 write_register_d=1, register_d=5, data_register_d_in=0xDEADBEEF; cycle 3 write_register_d=0.
3. All three valid continuously for 6 cycles -> grant order 0,1,2,0,1,2; one write per cycle; no requester starved.
4. Issue reg 7 at cycle 1 -> pending_a=1 for query_reg_a=7 from cycle 2; second issue of reg 7 sees issue_ready=0; req1 writes reg 7 at cycle 4 -> pending_a=1 during cycle 5 (write cycle), 0 from cycle 6; re-issue of reg 7 accepted in cycle 6.
5. wb_stall=1 with req2 valid for 3 cycles -> req_ready=000 and no writes; stall drops -> req2 granted next cycle, write one cycle later.
6. Grant at edge T, then reset=0 mid-cycle -> write_register_d drops to 0 immediately, and pending bits for regs 3 and 9 (issued earlier) read 0.
